// File: rtl/scan_sequencer.sv
// scan_sequencer: serialises parallel scan patterns into the internal scan
// chain, runs one capture cycle per pattern, and unloads the previous
// response while loading the next one. Responses leave as parallel words.
// Optional feature: define SCAN_SEQ_MISR_EN to add a 32-bit MISR signature
// over all consumed responses (output misr_sig).
module scan_sequencer #(
   parameter int CHAIN_LEN = 32,
   parameter int CNT_W     = 6
) (
   input  logic                 tck,
   input  logic                 trst,
   input  logic                 abort,
   input  logic                 pat_valid,
   output logic                 pat_ready,
   input  logic [CHAIN_LEN-1:0] pat_data,
   input  logic                 pat_last,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [CHAIN_LEN-1:0] rsp_data,
   input  logic                 sout,
   output logic                 sin,
   output logic                 shift,
   output logic                 test,
   output logic                 busy,
   output logic                 done
`ifdef SCAN_SEQ_MISR_EN
   ,
   output logic [31:0]          misr_sig
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_CAPTURE,
      ST_NEXT,
      ST_FLUSH
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

   state_t               state;
   state_t               state_n;
   logic [CNT_W-1:0]     cnt;
   logic [CHAIN_LEN-1:0] pat_sr;
   logic [CHAIN_LEN-1:0] rsp_sr;
   logic [CHAIN_LEN-1:0] rsp_sr_nxt;
   logic                 rsp_pend;
   logic                 last_q;
   logic                 pat_acc;
   logic                 flush_go;
   logic                 shifting;
   logic                 cnt_end;

   assign cnt_end    = (cnt == CNT_LAST);
   assign rsp_sr_nxt = {sout, rsp_sr[CHAIN_LEN-1:1]};

   // State register; abort is folded into the next-state logic
   always_ff @(posedge tck) begin
      if (!trst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state, scan pin decode and pattern handshake
   always_comb begin
      state_n   = state;
      sin       = 1'b0;
      shift     = 1'b0;
      test      = 1'b0;
      busy      = (state != ST_IDLE);
      pat_ready = trst & ~rsp_valid &
                  ((state == ST_IDLE) | ((state == ST_NEXT) & ~last_q));
      pat_acc   = pat_valid & pat_ready;
      flush_go  = 1'b0;
      shifting  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pat_acc) state_n = ST_SHIFT;
         end
         ST_SHIFT: begin
            sin      = pat_sr[0];
            shift    = 1'b1;
            test     = 1'b1;
            shifting = 1'b1;
            if (cnt_end) state_n = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            test    = 1'b1;
            state_n = ST_NEXT;
         end
         ST_NEXT: begin
            test = 1'b1;
            if (last_q) begin
               // Flush may only start once the previous word has left,
               // otherwise the flush result would overwrite it.
               if (!rsp_valid) begin
                  flush_go = 1'b1;
                  state_n  = ST_FLUSH;
               end
            end else if (pat_acc) begin
               state_n = ST_SHIFT;
            end
         end
         ST_FLUSH: begin
            sin      = pat_sr[0];
            shift    = 1'b1;
            test     = 1'b1;
            shifting = 1'b1;
            if (cnt_end) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
      if (abort) state_n = ST_IDLE;
   end

   // Shift registers, counter, response word and done pulse
   always_ff @(posedge tck) begin
      if (!trst) begin
         cnt       <= '0;
         pat_sr    <= '0;
         rsp_sr    <= '0;
         rsp_pend  <= 1'b0;
         last_q    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         done      <= 1'b0;
      end else if (abort) begin
         cnt       <= '0;
         rsp_pend  <= 1'b0;
         rsp_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
         if (pat_acc) begin
            pat_sr   <= pat_data;
            last_q   <= pat_last;
            // The first pattern after IDLE unloads stale chain contents,
            // which are not a response and must not be published.
            rsp_pend <= (state == ST_NEXT);
            cnt      <= '0;
         end else if (flush_go) begin
            pat_sr <= '0;
            cnt    <= '0;
         end else if (shifting) begin
            pat_sr <= pat_sr >> 1;
            rsp_sr <= rsp_sr_nxt;
            if (cnt_end) begin
               cnt <= '0;
               if (rsp_pend || state == ST_FLUSH) begin
                  rsp_data  <= rsp_sr_nxt;
                  rsp_valid <= 1'b1;
               end
               done <= (state == ST_FLUSH);
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

`ifdef SCAN_SEQ_MISR_EN
   localparam logic [31:0] MISR_POLY = 32'h0040_0007;

   logic [31:0] misr_word;

   if (CHAIN_LEN >= 32) begin : g_misr_trunc
      assign misr_word = rsp_data[31:0];
   end else begin : g_misr_ext
      assign misr_word = {{(32 - CHAIN_LEN){1'b0}}, rsp_data};
   end

   // Signature accumulates every consumed response of one run
   always_ff @(posedge tck) begin
      if (!trst) begin
         misr_sig <= '0;
      end else if (abort || (state == ST_IDLE && pat_acc)) begin
         misr_sig <= '0;
      end else if (rsp_valid && rsp_ready) begin
         misr_sig <= {misr_sig[30:0], 1'b0} ^
                     (misr_sig[31] ? MISR_POLY : 32'h0) ^ misr_word;
      end
   end
`endif

endmodule

// File: tb/tb_scan_sequencer.sv
// Testbench for scan_sequencer with an 8-flop scan chain model whose
// capture cycle inverts the chain contents.
module tb_scan_sequencer;

   localparam int N = 8;

   logic         tck = 1'b0;
   logic         trst;
   logic         abort;
   logic         pat_valid;
   logic         pat_ready;
   logic [N-1:0] pat_data;
   logic         pat_last;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [N-1:0] rsp_data;
   logic         sout;
   logic         sin;
   logic         shift;
   logic         test;
   logic         busy;
   logic         done;
`ifdef SCAN_SEQ_MISR_EN
   logic [31:0]  misr_sig;
`endif

   scan_sequencer #(.CHAIN_LEN(N), .CNT_W(4)) dut (
      .tck(tck), .trst(trst), .abort(abort),
      .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_data(pat_data), .pat_last(pat_last),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .sout(sout), .sin(sin), .shift(shift), .test(test), .busy(busy), .done(done)
`ifdef SCAN_SEQ_MISR_EN
      , .misr_sig(misr_sig)
`endif
   );

   always #5 tck = ~tck;

   // Scan chain model: sin enters at the top, sout is the bottom flop;
   // a capture is the first test cycle with shift low after shifting.
   logic [N-1:0] chain = '0;
   logic         shifted_q = 1'b0;
   assign sout = chain[0];
   always @(posedge tck) begin
      if (test && shift)          chain <= {sin, chain[N-1:1]};
      else if (test && shifted_q) chain <= ~chain;
      shifted_q <= test && shift;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, got, exp);
   endtask

   // Reference model: each accepted pattern yields ~pattern, in order.
   logic [N-1:0] exp_q[$];
   logic [N-1:0] got_q[$];
   int           acc_q[$];
   bit           pending_last = 0;
   bit           armed = 0;
   logic [N-1:0] held = '0;
   int           cyc = 0;
   logic [31:0]  misr_m = '0;

   initial forever begin
      @(posedge tck);
      if (!trst || abort) begin
         exp_q.delete();
         pending_last = 0;
         armed = 0;
         misr_m = '0;
      end else begin
         if (armed) begin
            chk("rsp_hold_valid", rsp_valid, 1);
            chk("rsp_hold_data", rsp_data, held);
         end
         if (done) begin
            chk("done_expected", pending_last, 1);
            chk("done_with_rsp", rsp_valid, 1);
            pending_last = 0;
         end
`ifdef SCAN_SEQ_MISR_EN
         chk("misr_sig", misr_sig, misr_m);
`endif
         if (rsp_valid && rsp_ready) begin
            got_q.push_back(rsp_data);
            chk("rsp_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("rsp_data_model", rsp_data, exp_q.pop_front());
            misr_m = {misr_m[30:0], 1'b0} ^ (misr_m[31] ? 32'h0040_0007 : 32'h0) ^ {24'h0, rsp_data};
         end
         if (pat_valid && pat_ready) begin
            exp_q.push_back(~pat_data);
            acc_q.push_back(cyc);
            if (pat_last) pending_last = 1;
            if (!busy) misr_m = '0;
         end
         armed = rsp_valid && !rsp_ready;
         held  = rsp_data;
      end
      cyc++;
   end

   task automatic tick();
      @(posedge tck);
      #1;
   endtask

   task automatic wait_pat_ready(input string name, input int maxc);
      int c = 0;
      while (!pat_ready && c < maxc) begin tick(); c++; end
      chk({name, "_ready_timeout"}, pat_ready, 1);
   endtask

   task automatic wait_rsp_valid(input string name, input int maxc);
      int c = 0;
      while (!rsp_valid && c < maxc) begin tick(); c++; end
      chk({name, "_rsp_timeout"}, rsp_valid, 1);
   endtask

   task automatic wait_idle(input string name, input int maxc);
      int c = 0;
      while ((busy || rsp_valid) && c < maxc) begin tick(); c++; end
      chk({name, "_idle_timeout"}, (busy || rsp_valid), 0);
   endtask

   task automatic send(input string name, input logic [N-1:0] d, input logic last);
      wait_pat_ready(name, 100);
      pat_valid = 1'b1;
      pat_data  = d;
      pat_last  = last;
      tick();
      pat_valid = 1'b0;
   endtask

   typedef struct {
      logic [N-1:0] pat;
      logic [N-1:0] rsp;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{pat: 8'hA5, rsp: 8'h5A};
      vecs[1] = '{pat: 8'h00, rsp: 8'hFF};
      vecs[2] = '{pat: 8'hFF, rsp: 8'h00};
      vecs[3] = '{pat: 8'h01, rsp: 8'hFE};
      vecs[4] = '{pat: 8'h80, rsp: 8'h7F};
      vecs[5] = '{pat: 8'h3C, rsp: 8'hC3};

      trst = 1'b0; abort = 1'b0; pat_valid = 1'b0; pat_data = '0;
      pat_last = 1'b0; rsp_ready = 1'b0;

      // Reset
      tick(); tick();
      chk("rst_pat_ready", pat_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_shift_test_sin", {shift, test, sin}, 0);
      trst = 1'b1;
      #1;
      chk("post_rst_pat_ready", pat_ready, 1);

      // Single pattern with cycle-exact timing
      pat_valid = 1'b1; pat_data = 8'hA5; pat_last = 1'b1;
      tick();
      pat_valid = 1'b0;
      chk("single_e0_shift_test", {shift, test, busy}, 3'b111);
      for (int e = 1; e <= 19; e++) begin
         tick();
         if (e == 8)  chk("single_capture", {shift, test}, 2'b01);
         if (e == 10) chk("single_flush", {shift, test}, 2'b11);
         if (e == 17) chk("single_done_early", {done, rsp_valid}, 0);
         if (e == 18) begin
            chk("single_done", done, 1);
            chk("single_rsp_valid", rsp_valid, 1);
            chk("single_rsp_data", rsp_data, 8'h5A);
            chk("single_busy", busy, 0);
         end
         if (e == 19) chk("single_done_pulse", {done, rsp_valid}, 2'b01);
      end
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

      // Table of single-pattern runs
      foreach (vecs[i]) begin
         send("vec", vecs[i].pat, 1'b1);
         wait_rsp_valid("vec", 40);
         chk($sformatf("vec%0d_rsp", i), rsp_data, vecs[i].rsp);
         chk($sformatf("vec%0d_done", i), done, 1);
         rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
      end

      // Back-to-back patterns
      got_q.delete(); acc_q.delete();
      rsp_ready = 1'b1;
      send("b2b", 8'h01, 1'b0);
      send("b2b", 8'h80, 1'b0);
      send("b2b", 8'hFF, 1'b1);
      wait_idle("b2b", 60);
      chk("b2b_rsp_count", got_q.size(), 3);
      chk("b2b_accept_count", acc_q.size(), 3);
      if (got_q.size() == 3) begin
         chk("b2b_rsp0", got_q[0], 8'hFE);
         chk("b2b_rsp1", got_q[1], 8'h7F);
         chk("b2b_rsp2", got_q[2], 8'h00);
      end
      if (acc_q.size() == 3) begin
         chk("b2b_2nd_accept", acc_q[1] - acc_q[0], 10);
         chk("b2b_3rd_accept", acc_q[2] - acc_q[0], 20);
      end

      // Backpressure on the response stream
      got_q.delete();
      rsp_ready = 1'b0;
      send("bp", 8'h11, 1'b0);
      send("bp", 8'h22, 1'b0);
      pat_valid = 1'b1; pat_data = 8'h33; pat_last = 1'b1;
      wait_rsp_valid("bp", 40);
      for (int i = 0; i < 20; i++) begin
         chk("bp_pat_ready", pat_ready, 0);
         chk("bp_rsp_data", rsp_data, 8'hEE);
         chk("bp_hold_next", {shift, test, busy}, 3'b011);
         tick();
      end
      rsp_ready = 1'b1;
      wait_pat_ready("bp", 10);
      tick();
      pat_valid = 1'b0;
      wait_idle("bp", 60);
      chk("bp_rsp_count", got_q.size(), 3);
      if (got_q.size() == 3) begin
         chk("bp_rsp0", got_q[0], 8'hEE);
         chk("bp_rsp1", got_q[1], 8'hDD);
         chk("bp_rsp2", got_q[2], 8'hCC);
      end

      // Abort in the middle of shifting, then restart
      got_q.delete();
      send("abort", 8'hF0, 1'b0);
      tick(); tick(); tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_idle", {shift, test, busy, rsp_valid}, 0);
      send("abort", 8'h3C, 1'b1);
      wait_idle("abort", 60);
      chk("abort_rsp_count", got_q.size(), 1);
      if (got_q.size() == 1) chk("abort_rsp", got_q[0], 8'hC3);

      // Randomized traffic against the reference model
      for (int i = 0; i < 1500; i++) begin
         pat_valid = ($urandom_range(2) != 0);
         pat_data  = N'($urandom);
         pat_last  = ($urandom_range(3) == 0);
         rsp_ready = ($urandom_range(2) != 0);
         abort     = ($urandom_range(299) == 0);
         tick();
      end
      abort = 1'b0; pat_valid = 1'b0; rsp_ready = 1'b1;
      send("drain", 8'h96, 1'b1);
      wait_idle("drain", 300);
      chk("final_model_empty", exp_q.size(), 0);
      chk("final_no_pending_done", pending_last, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

endmodule
